// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the instruction-memory boot loader.
//   - loader_state_e  : loader FSM state encoding
//   - HDR_WIDTH       : width of the big-endian word-count header
//   - BYTES_PER_WORD  : stream bytes per instruction word
//   - accepts_byte()  : states in which the loader takes a stream byte
// -----------------------------------------------------------------------------
package loader_pkg;

    typedef enum logic [2:0] {
        BOOT,
        HDR_HI,
        HDR_LO,
        DATA,
        WRITE,
        CHK,
        DONE,
        ERROR
    } loader_state_e;

    localparam int HDR_WIDTH      = 16;
    localparam int BYTES_PER_WORD = 4;

    // Byte-accepting states. CHK is only reachable when the checksum
    // option is compiled in, so listing it here costs nothing otherwise.
    function automatic logic accepts_byte(input loader_state_e s);
        return (s == HDR_HI) || (s == HDR_LO) || (s == DATA) || (s == CHK);
    endfunction

endpackage

// File: rtl/word_assembler.sv
// -----------------------------------------------------------------------------
// word_assembler
// Collects stream bytes into a big-endian instruction word: the first byte
// shifted in ends up in bits [31:24].
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   clear        : restart byte counting for a new image
//   shift_en     : a byte is being accepted this cycle
//   byte_in      : the accepted byte
//   word         : registered assembled word
//   word_full    : this cycle's byte completes the word
// -----------------------------------------------------------------------------
module word_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_full
);

    localparam int CW = $clog2(BYTES_PER_WORD);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   word_q, word_d;

    // Counter wraps naturally after the last byte, so the next word
    // starts cleanly without an explicit reset.
    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clear) begin
            cnt_d = '0;
        end else if (shift_en) begin
            word_d = {word_q[23:0], byte_in};
            cnt_d  = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

    assign word      = word_q;
    assign word_full = shift_en && (cnt_q == CW'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instr_mem_loader.sv
// -----------------------------------------------------------------------------
// instr_mem_loader
// Boot-time writer for instruction memory. Receives a byte stream carrying a
// 16-bit big-endian word count followed by big-endian 32-bit words, writes
// each word to consecutive word addresses starting at BASE_ADDR, and holds
// the processor in reset until the whole image has been written.
// Optional macro LOADER_CHECKSUM_EN: a trailing byte equal to the XOR of all
// payload bytes must follow the image; a mismatch ends in ERROR.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   start             : pulse to reload from DONE or ERROR
//   in_valid/in_data  : byte stream input
//   in_ready          : loader accepts a byte this cycle
//   mem_we/mem_addr/mem_wdata : instruction-memory write port
//   core_rst          : active-high processor reset, released in DONE
//   done, error       : load status
// -----------------------------------------------------------------------------
module instr_mem_loader
    import loader_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int unsigned           DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  core_rst,
    output logic                  done,
    output logic                  error
);

`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_e AFTER_PAYLOAD = CHK;
`else
    localparam loader_state_e AFTER_PAYLOAD = DONE;
`endif

    loader_state_e          state_q, state_d;
    logic [HDR_WIDTH-1:0]   count_q, count_d;
    logic [HDR_WIDTH-1:0]   idx_q, idx_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [HDR_WIDTH-1:0]   hdr_full;
    logic                   xfer;
    logic                   asm_clear;
    logic                   asm_shift;
    logic                   word_full;
    logic [31:0]            asm_word;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]             chk_q, chk_d;
`endif

    assign in_ready = accepts_byte(state_q);
    assign xfer     = in_valid && in_ready;
    assign hdr_full = {count_q[15:8], in_data};

    word_assembler u_asm (
        .clk       (clk),
        .rst       (rst),
        .clear     (asm_clear),
        .shift_en  (asm_shift),
        .byte_in   (in_data),
        .word      (asm_word),
        .word_full (word_full)
    );

    // Next-state logic. The address register tracks BASE_ADDR + 4*index
    // incrementally so no multiplier is needed on the write path.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        asm_clear = 1'b0;
        asm_shift = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        chk_d     = chk_q;
`endif
        case (state_q)
            BOOT: state_d = HDR_HI;
            HDR_HI: begin
                if (xfer) begin
                    count_d = {in_data, count_q[7:0]};
                    state_d = HDR_LO;
                end
            end
            HDR_LO: begin
                if (xfer) begin
                    count_d = hdr_full;
                    if (hdr_full == '0) begin
                        state_d = AFTER_PAYLOAD;
                    end else if ({16'd0, hdr_full} > DEPTH) begin
                        state_d = ERROR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    asm_shift = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    chk_d = chk_q ^ in_data;
`endif
                    if (word_full) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                idx_d  = idx_q + 16'd1;
                addr_d = addr_q + ADDR_WIDTH'(BYTES_PER_WORD);
                state_d = (idx_d == count_q) ? AFTER_PAYLOAD : DATA;
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                if (xfer) begin
                    state_d = (in_data == chk_q) ? DONE : ERROR;
                end
            end
`endif
            DONE, ERROR: begin
                if (start) begin
                    idx_d     = '0;
                    addr_d    = BASE_ADDR;
                    asm_clear = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    chk_d     = '0;
`endif
                    state_d   = HDR_HI;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BOOT;
            count_q <= '0;
            idx_q   <= '0;
            addr_q  <= BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
            chk_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
`ifdef LOADER_CHECKSUM_EN
            chk_q   <= chk_d;
`endif
        end
    end

    // Status outputs are pure decodes of the state register, so core_rst
    // falls on exactly the edge that done rises.
    assign mem_we    = (state_q == WRITE);
    assign mem_addr  = addr_q;
    assign mem_wdata = asm_word;
    assign core_rst  = (state_q != DONE);
    assign done      = (state_q == DONE);
    assign error     = (state_q == ERROR);

endmodule

// File: tb/tb_instr_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_mem_loader
// Drives directed and randomized byte images into instr_mem_loader and checks
// memory writes and status against an image-level reference model.
// Honours LOADER_CHECKSUM_EN by appending the XOR trailer to every image.
// -----------------------------------------------------------------------------
module tb_instr_mem_loader;

    localparam int          ADDR_W = 32;
    localparam logic [31:0] BASE   = 32'h0;
    localparam int          DEPTH  = 256;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              core_rst;
    logic              done;
    logic              error;

    int checkCount = 0;
    int failCount  = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         expQ[$];
    wr_t         monW;
    logic [31:0] imgWords[$];

    instr_mem_loader #(
        .ADDR_WIDTH (ADDR_W),
        .BASE_ADDR  (BASE),
        .DEPTH      (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .core_rst  (core_rst),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Every write strobe must match the next write the image predicts.
    always @(negedge clk) begin
        if (rst) begin
            checkOutput("coreRstVsDone", core_rst, !done);
            if (mem_we) begin
                checkOutput("readyInWrite", in_ready, 0);
                if (expQ.size() == 0) begin
                    checkOutput("writeOverrun", 64'(expQ.size()), 1);
                end else begin
                    monW = expQ.pop_front();
                    checkOutput("writeAddr", mem_addr, monW.addr);
                    checkOutput("writeData", mem_wdata, monW.data);
                end
            end
        end
    end

    task automatic checkReset(input string tag);
        checkOutput({tag, "_inReady"}, in_ready, 0);
        checkOutput({tag, "_memWe"}, mem_we, 0);
        checkOutput({tag, "_memAddr"}, mem_addr, BASE);
        checkOutput({tag, "_memWdata"}, mem_wdata, 0);
        checkOutput({tag, "_coreRst"}, core_rst, 1);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_error"}, error, 0);
    endtask

    // Enters and leaves at a falling edge; the byte transfers on the
    // rising edge in between once in_ready is seen high.
    task automatic sendByte(input logic [7:0] b, input int gapMax);
        int guard = 0;
        repeat ($urandom_range(gapMax, 0)) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) checkOutput("readyTimeout", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic waitFinal(input bit expDone, input bit expErr);
        int guard = 0;
        while (!(done || error) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("finalDone", done, expDone);
        checkOutput("finalError", error, expErr);
        checkOutput("finalCoreRst", core_rst, !expDone);
        checkOutput("finalInReady", in_ready, 0);
        checkOutput("pendingWrites", 64'(expQ.size()), 0);
        expQ.delete();
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("startDone", done, 0);
        checkOutput("startError", error, 0);
        checkOutput("startCoreRst", core_rst, 1);
    endtask

    // Reference model: an image of cnt words from imgWords. Oversized images
    // write nothing and fail; otherwise word i lands at BASE + 4*i, and with
    // the checksum option a corrupted trailer turns the outcome into ERROR.
    task automatic applyStimulus(input logic [15:0] cnt, input int gapMax, input bit corruptChk);
        logic [7:0]  x;
        logic [31:0] w;
        bit          expErr;
        x = 8'h00;
        expErr = (int'(cnt) > DEPTH);
        if (!expErr) begin
            for (int i = 0; i < int'(cnt); i++) begin
                expQ.push_back('{addr: BASE + 32'(4 * i), data: imgWords[i]});
            end
        end
        sendByte(cnt[15:8], gapMax);
        sendByte(cnt[7:0], gapMax);
        if (!expErr) begin
            for (int i = 0; i < int'(cnt); i++) begin
                w = imgWords[i];
                for (int b = 0; b < 4; b++) begin
                    x ^= w[8*(3-b) +: 8];
                    sendByte(w[8*(3-b) +: 8], gapMax);
                end
            end
            if (CHK_EN) begin
                sendByte(corruptChk ? (x ^ 8'h01) : x, gapMax);
                expErr = corruptChk;
            end
        end
        waitFinal(!expErr, expErr);
    endtask

    task automatic randomWords(input int n);
        imgWords.delete();
        for (int i = 0; i < n; i++) imgWords.push_back($urandom);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        logic [31:0] w;

        repeat (2) @(negedge clk);
        checkReset("por");
        rst = 1'b1;
        @(negedge clk);
        checkOutput("hdrReady", in_ready, 1);

        $display("[TB] two-word directed image");
        imgWords = '{32'h20080005, 32'h8C090004};
        applyStimulus(16'd2, 0, 1'b0);

        $display("[TB] empty image after reset");
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(16'd0, 0, 1'b0);

        $display("[TB] oversized header then recovery");
        pulseStart();
        applyStimulus(16'h0101, 0, 1'b0);
        pulseStart();
        randomWords(2);
        applyStimulus(16'd2, 1, 1'b0);

        $display("[TB] randomized images with stream gaps");
        for (int k = 0; k < 6; k++) begin
            pulseStart();
            n = (k == 0) ? 3 : int'($urandom_range(4, 1));
            randomWords(n);
            applyStimulus(16'(n), 3, 1'b0);
        end

        $display("[TB] reset in the middle of a load");
        pulseStart();
        randomWords(2);
        expQ.push_back('{addr: BASE, data: imgWords[0]});
        sendByte(8'h00, 1);
        sendByte(8'h02, 1);
        for (int b = 0; b < 5; b++) begin
            w = imgWords[b / 4];
            sendByte(w[8*(3-(b % 4)) +: 8], 1);
        end
        rst = 1'b0;
        #1;
        checkReset("midReset");
        checkOutput("midResetWrites", 64'(expQ.size()), 0);
        expQ.delete();
        @(negedge clk);
        rst = 1'b1;
        randomWords(1);
        applyStimulus(16'd1, 1, 1'b0);

        if (CHK_EN) begin
            $display("[TB] checksum trailer match and mismatch");
            pulseStart();
            imgWords = '{32'h12345678};
            applyStimulus(16'd1, 0, 1'b0);
            pulseStart();
            applyStimulus(16'd1, 0, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
